fb_fill_sequencer: RTL and testbench
====================================

Name: fb_fill_sequencer

Overview:
- Sequences rectangle-fill writes into the shared frame-buffer RAM (one palette index per pixel, address = x + WIDTH*y) while keeping VGA scan-out reads uninterrupted.
- Owns the RAM address/write-enable mux: scan-out address passes through on every cycle except one write slot per pixel period.
- Game logic (paddles, ball, score) issues fill commands through a valid/ready handshake. Commands can be deferred to the frame boundary for tear-free updates.

Parameters:
- WIDTH, 640, visible pixels per line.
- HEIGHT, 480, visible lines.
- ADDR_W, 19, frame-buffer address width.
- DATA_W, 9, palette index width.
- WRITE_PHASE, 2, value of pix_phase that marks the single write slot.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- pix_phase  in  2  free-running 100→25 MHz divider count.
- frame_end  in  1  one-cycle pulse between frames.
- scan_addr  in  ADDR_W  scan-out read address.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_x  in  10  rectangle left edge.
- cmd_y  in  9  rectangle top edge.
- cmd_w  in  10  rectangle width in pixels.
- cmd_h  in  9  rectangle height in pixels.
- cmd_color  in  DATA_W  palette index to write.
- cmd_sync  in  1  1 = hold the command until the next frame_end.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_wEn  out  1  RAM write enable.
- busy  out  1  a command is held or executing.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (reset=0, async): state IDLE; cmd_ready=0; busy=0; done=0; mem_wEn=0; mem_wdata=0; all latched command fields and counters cleared; mem_addr=scan_addr.
- First clk edge after reset deasserts: cmd_ready=1.
- Reset mid-fill: operation aborts immediately; no done pulse; pixels already written stay written.
- States: IDLE, WAIT_FRAME, FILL, DONE.
- IDLE, accept on cmd_valid&&cmd_ready rising edge:
  - Latch x0, y0, colour.
  - Compute clipped extents: xe=min(x0+w, WIDTH) and ye=min(y0+h, HEIGHT), with 11-bit/10-bit sums so nothing wraps.
  - Set cx=x0, cy=y0, row_base=WIDTH*y0 (ADDR_W bits).
  - cmd_ready→0 and busy→1 on the same edge.
  - Next state: WAIT_FRAME if cmd_sync=1; DONE if the clipped area is empty (w=0, h=0, x0≥WIDTH or y0≥HEIGHT); otherwise FILL.
- WAIT_FRAME: waits for a frame_end pulse seen in a cycle after the accept cycle (a frame_end coincident with accept is ignored). Then goes to DONE if the area is empty, else FILL.
- FILL:
  - mem_wEn=1 combinationally only when pix_phase==WRITE_PHASE; mem_addr=row_base+cx in that cycle; mem_wdata=colour.
  - On each write cycle, cx increments.
  - If cx+1==xe: cx←x0, cy←cy+1, row_base←row_base+WIDTH (incremental, no multiplier in the loop).
  - If cx+1==xe and cy+1==ye: go to DONE.
  - Exactly one write per 4-clock pixel period. A fill of N clipped pixels issues exactly N writes, in raster order, at addresses x+WIDTH*y.
- DONE: done=1 for exactly one cycle; busy=0 and cmd_ready=1 from the next cycle; next state IDLE. Back-to-back commands are possible: the next accept can occur the cycle after DONE.
- Outside write cycles: mem_addr=scan_addr and mem_wEn=0. Scan-out is never stalled, and it owns 3 of every 4 clocks.
- mem_wdata holds the latched colour while busy; it has no meaning when mem_wEn=0.
- cmd_* inputs are ignored when cmd_ready=0.
- Latency: with FILL entered at edge T, the first write occurs at the first cycle ≥T with pix_phase==WRITE_PHASE. Total FILL duration ≤ 4·N+3 clocks.

Test Plan:
- Reset then cmd x=10, y=2, w=3, h=2, colour=0x1A5, sync=0 → exactly 6 writes at 1290, 1291, 1292, 1930, 1931, 1932, each with pix_phase=2 and wdata=0x1A5; then one done pulse, then cmd_ready=1.
- Clipping: x=638, y=479, w=5, h=4 → writes only at 307198 and 307199, then done. Also x=700 → no writes and done 2 cycles after accept.
- Sync deferral: cmd_sync=1 accepted together with a coincident frame_end → no writes until the next frame_end pulse; writes begin within 4 clocks after it.
- Scan-out transparency: scan_addr ramping during a fill → mem_addr equals scan_addr on every cycle where pix_phase≠2; when idle, mem_wEn never asserts.
- Reset asserted after 3 of 6 writes → mem_wEn drops asynchronously, no done pulse, cmd_ready=0 during reset; a new command is accepted normally after release.
- Back-to-back: cmd_valid held high with two queued commands → second accepted the cycle after the first's done; no overlapping writes; w=0 command → done pulse with zero writes.

Source files
------------

// File: rtl/fb_fill_sequencer.sv
// Rectangle-fill sequencer for the shared frame-buffer RAM.
// Scan-out owns the RAM address on three of every four clocks. The fourth
// clock (pix_phase == WRITE_PHASE) is a write slot that is used only while a
// fill is running. Game logic hands over commands through a valid/ready
// handshake. A command may be held until the next frame boundary so that the
// screen update does not tear.
module fb_fill_sequencer #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 9,
    parameter int WRITE_PHASE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        pix_phase,
    input  logic              frame_end,
    input  logic [ADDR_W-1:0] scan_addr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic [DATA_W-1:0] cmd_color,
    input  logic              cmd_sync,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wEn,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_FRAME = 2'd1;
    localparam logic [1:0] S_FILL       = 2'd2;
    localparam logic [1:0] S_DONE       = 2'd3;

    logic [1:0]        state;
    logic              ready_r;
    logic              busy_r;

    // Latched command and raster walk counters
    logic [9:0]        x0;
    logic [9:0]        cx;
    logic [8:0]        cy;
    logic [10:0]       xe;
    logic [9:0]        ye;
    logic [ADDR_W-1:0] row_base;
    logic [DATA_W-1:0] color;
    logic              empty;

    // Decode of the incoming command (only meaningful in the accept cycle)
    logic              accept;
    logic [10:0]       x_sum;
    logic [9:0]        y_sum;
    logic              cmd_empty;

    // Walk-position decode for the current write slot
    logic              write_slot;
    logic              row_last;
    logic              col_last;

    // Decode the incoming command: clipped extents and empty-area test.
    always_comb begin
        accept    = cmd_valid && ready_r;
        x_sum     = {1'b0, cmd_x} + {1'b0, cmd_w};
        y_sum     = {1'b0, cmd_y} + {1'b0, cmd_h};
        cmd_empty = (cmd_w == 10'd0) || (cmd_h == 9'd0) ||
                    ({1'b0, cmd_x} >= 11'(WIDTH)) ||
                    ({1'b0, cmd_y} >= 10'(HEIGHT));
    end

    // Write-slot decode and end-of-row / end-of-rectangle detection.
    always_comb begin
        write_slot = (state == S_FILL) && (pix_phase == 2'(WRITE_PHASE));
        row_last   = (({1'b0, cx} + 11'd1) == xe);
        col_last   = (({1'b0, cy} + 10'd1) == ye);
    end

    // RAM port mux: scan-out passes through except in an active write slot.
    always_comb begin
        mem_wEn   = write_slot;
        mem_addr  = write_slot ? (row_base + ADDR_W'(cx)) : scan_addr;
        mem_wdata = color;
        cmd_ready = ready_r;
        busy      = busy_r;
        done      = (state == S_DONE);
    end

    // Sequencer control: handshake, frame-sync hold, fill and completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        if (cmd_sync)
                            state <= S_WAIT_FRAME;
                        else if (cmd_empty)
                            state <= S_DONE;
                        else
                            state <= S_FILL;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                S_WAIT_FRAME: begin
                    if (frame_end)
                        state <= empty ? S_DONE : S_FILL;
                end
                S_FILL: begin
                    if (write_slot && row_last && col_last)
                        state <= S_DONE;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Command latch on accept, then raster walk advanced once per write slot.
    // Row base steps by WIDTH so the loop needs no multiplier.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x0       <= '0;
            cx       <= '0;
            cy       <= '0;
            xe       <= '0;
            ye       <= '0;
            row_base <= '0;
            color    <= '0;
            empty    <= 1'b0;
        end else if (state == S_IDLE && accept) begin
            x0       <= cmd_x;
            cx       <= cmd_x;
            cy       <= cmd_y;
            xe       <= (x_sum > 11'(WIDTH))  ? 11'(WIDTH)  : x_sum;
            ye       <= (y_sum > 10'(HEIGHT)) ? 10'(HEIGHT) : y_sum;
            row_base <= ADDR_W'(WIDTH) * ADDR_W'(cmd_y);
            color    <= cmd_color;
            empty    <= cmd_empty;
        end else if (write_slot) begin
            if (row_last) begin
                cx       <= x0;
                cy       <= cy + 9'd1;
                row_base <= row_base + ADDR_W'(WIDTH);
            end else begin
                cx <= cx + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_fb_fill_sequencer.sv
// Bench for fb_fill_sequencer: directed cases plus randomized rectangles,
// checked against a raster-order list of expected (colour, address) writes.
module tb_fb_fill_sequencer;

    logic        clk;
    logic        reset;
    logic [1:0]  pix_phase;
    logic        frame_end;
    logic [18:0] scan_addr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [9:0]  cmd_w;
    logic [8:0]  cmd_h;
    logic [8:0]  cmd_color;
    logic        cmd_sync;
    logic [18:0] mem_addr;
    logic [8:0]  mem_wdata;
    logic        mem_wEn;
    logic        busy;
    logic        done;

    int          n_vec;
    int          n_err;
    int          done_cnt;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    fb_fill_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .pix_phase (pix_phase),
        .frame_end (frame_end),
        .scan_addr (scan_addr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .cmd_sync  (cmd_sync),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wEn   (mem_wEn),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running pixel divider and a randomly wandering scan address.
    initial begin
        pix_phase = 2'd0;
        scan_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            pix_phase = pix_phase + 2'd1;
            scan_addr = 19'($urandom_range(0, 307199));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: every clipped pixel of the rectangle in raster order.
    function automatic int push_exp(input int x, input int y, input int w, input int h, input int col);
        int n;
        logic [31:0] e;
        n = 0;
        for (int yy = y; yy < y + h && yy < 480; yy++) begin
            for (int xx = x; xx < x + w && xx < 640; xx++) begin
                e = 32'((col << 19) | (xx + 640 * yy));
                exp_q.push_back(e);
                n++;
            end
        end
        return n;
    endfunction

    // Write-port monitor: each write must match the next expected pixel;
    // every other cycle must show the scan address untouched.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_wEn) begin
                check_eq("wr_phase", 32'(pix_phase), 32'd2);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_wEn", 32'(mem_wEn), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("wr_addr", 32'(mem_addr), {13'd0, mon_e[18:0]});
                    check_eq("wr_data", 32'(mem_wdata), {23'd0, mon_e[27:19]});
                end
            end else begin
                check_eq("scan_pass", 32'(mem_addr), 32'(scan_addr));
            end
            if (done) begin
                done_cnt++;
                check_eq("done_pending", 32'(exp_q.size()), 32'd0);
            end
        end
    end

    task automatic send_cmd(input int x, input int y, input int w, input int h, input int col,
                            input bit sync, input bit fe, input bit hold, output int n);
        int k;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check_eq("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_x     = x[9:0];
        cmd_y     = y[8:0];
        cmd_w     = w[9:0];
        cmd_h     = h[8:0];
        cmd_color = col[8:0];
        cmd_sync  = sync;
        cmd_valid = 1'b1;
        frame_end = fe;
        @(posedge clk);
        #1;
        n = push_exp(x, y, w, h, col);
        frame_end = 1'b0;
        if (!hold) cmd_valid = 1'b0;
        check_eq("acc_ready_low", 32'(cmd_ready), 32'd0);
        check_eq("acc_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int bound, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc = 0;
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("ready_after_done", 32'(cmd_ready), 32'd1);
        check_eq("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int cyc;
        int k;
        int d0;
        int x, y, w, h;
        bit s;

        n_vec = 0; n_err = 0; done_cnt = 0;
        reset = 1'b0;
        frame_end = 1'b0;
        cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0; cmd_sync = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_wEn", 32'(mem_wEn), 32'd0);
        check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
        #2;
        reset = 1'b1;
        check_eq("ready_pre_edge", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("ready_first_edge", 32'(cmd_ready), 32'd1);

        // Basic 3x2 fill
        send_cmd(10, 2, 3, 2, 'h1A5, 1'b0, 1'b0, 1'b0, n);
        wait_done(4 * n + 10, cyc);
        check_eq("basic_len_ok", 32'(cyc <= 4 * n + 4), 32'd1);
        check_eq("basic_queue", 32'(exp_q.size()), 32'd0);

        // Clip at bottom-right corner
        send_cmd(638, 479, 5, 4, 'h033, 1'b0, 1'b0, 1'b0, n);
        check_eq("clip_count", 32'(n), 32'd2);
        wait_done(4 * n + 10, cyc);

        // Entirely off-screen
        send_cmd(700, 10, 4, 4, 'h0FF, 1'b0, 1'b0, 1'b0, n);
        wait_done(10, cyc);
        check_eq("offscreen_lat_ok", 32'(cyc <= 2), 32'd1);

        // Frame-synchronised command with a coincident frame_end
        send_cmd(20, 30, 2, 2, 'h155, 1'b1, 1'b1, 1'b0, n);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("sync_hold_wEn", 32'(mem_wEn), 32'd0);
        end
        check_eq("sync_hold_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        frame_end = 1'b1;
        @(posedge clk); #1;
        frame_end = 1'b0;
        k = 0;
        while (k < 8) begin
            @(negedge clk);
            k++;
            if (mem_wEn) break;
        end
        check_eq("sync_start_ok", 32'(k <= 4), 32'd1);
        wait_done(4 * n + 10, cyc);

        // Reset after three of six writes
        send_cmd(100, 100, 3, 2, 'h0AA, 1'b0, 1'b0, 1'b0, n);
        k = 0;
        while (exp_q.size() > 3 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        check_eq("abort_progress", 32'(exp_q.size()), 32'd3);
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        check_eq("abort_wEn", 32'(mem_wEn), 32'd0);
        check_eq("abort_ready", 32'(cmd_ready), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_addr", 32'(mem_addr), 32'(scan_addr));
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_eq("abort_ready_hold", 32'(cmd_ready), 32'd0);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_ready_rel", 32'(cmd_ready), 32'd1);
        check_eq("abort_no_done", 32'(done_cnt), 32'(d0));
        send_cmd(5, 5, 2, 1, 'h1C3, 1'b0, 1'b0, 1'b0, n);
        wait_done(4 * n + 10, cyc);

        // Back-to-back: valid held, second accepted right after done
        send_cmd(50, 60, 2, 2, 'h011, 1'b0, 1'b0, 1'b1, n);
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (done) break;
        end
        check_eq("b2b_first_done", 32'(done), 32'd1);
        cmd_w = 10'd0;
        cmd_color = 9'h122;
        @(negedge clk);
        check_eq("b2b_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_eq("b2b_accepted", 32'(cmd_ready), 32'd0);
        check_eq("b2b_busy", 32'(busy), 32'd1);
        d0 = done_cnt;
        wait_done(10, cyc);
        check_eq("b2b_zero_done", 32'(done_cnt), 32'(d0 + 1));

        // Randomized rectangles
        for (int t = 0; t < 14; t++) begin
            x = ($urandom_range(0, 1) != 0) ? int'($urandom_range(630, 700)) : int'($urandom_range(0, 629));
            y = ($urandom_range(0, 1) != 0) ? int'($urandom_range(470, 511)) : int'($urandom_range(0, 469));
            w = $urandom_range(0, 5);
            h = $urandom_range(0, 3);
            s = 1'($urandom_range(0, 1));
            send_cmd(x, y, w, h, int'($urandom_range(0, 511)), s, 1'($urandom_range(0, 1)), 1'b0, n);
            if (s) begin
                repeat ($urandom_range(1, 8)) @(posedge clk);
                #1;
                frame_end = 1'b1;
                @(posedge clk); #1;
                frame_end = 1'b0;
            end
            wait_done(4 * n + 20, cyc);
            if (!s) check_eq("rand_len_ok", 32'(cyc <= 4 * n + 4), 32'd1);
        end

        repeat (4) @(negedge clk);
        check_eq("final_queue", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
